// File: rtl/sensor_link_pkg.sv
// Shared types and helpers for the byte-strobe sensor link (transmitter and receiver).
// SENSOR_LINK_CHKSUM_EN adds a third, checksum byte to every frame.
package sensor_link_pkg;

    localparam int SL_BYTE_W = 8;

`ifdef SENSOR_LINK_CHKSUM_EN
    localparam int SL_FRAME_LEN = 3;

    typedef enum logic [2:0] {
        SL_IDLE,
        SL_SEND0,
        SL_GAP,
        SL_SEND1,
        SL_SENDC,
        SL_TAIL
    } sl_state_t;
`else
    localparam int SL_FRAME_LEN = 2;

    typedef enum logic [2:0] {
        SL_IDLE,
        SL_SEND0,
        SL_GAP,
        SL_SEND1,
        SL_TAIL
    } sl_state_t;
`endif

    function automatic logic [SL_BYTE_W-1:0] sl_chk(input logic [SL_BYTE_W-1:0] a,
                                                    input logic [SL_BYTE_W-1:0] b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/sl_gap_timer.sv
// Loadable down-counter that saturates at zero; flags zero and the final counting cycle.
module sl_gap_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/sensor_link_tx.sv
// Sample-pair to strobed-byte frame transmitter with a one-frame holding buffer.
// SENSOR_LINK_CHKSUM_EN appends a rain^soil checksum strobe to every frame.
module sensor_link_tx
    import sensor_link_pkg::*;
#(
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SL_BYTE_W-1:0] rain,
    input  logic [SL_BYTE_W-1:0] soil,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SL_BYTE_W-1:0] data_bus,
    output logic                 ss,
    output logic                 busy,
    output logic                 frame_done
);

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);
    localparam bit         NO_GAP   = (GAP_CYCLES == 0);
    localparam int         WORK_W   = (SL_FRAME_LEN - 1) * SL_BYTE_W;

    sl_state_t                  state;
    logic [2*SL_BYTE_W-1:0]     hold;
    logic                       full;
    logic [WORK_W-1:0]          work;
    logic                       tmr_load;
    logic                       tmr_zero;
    logic                       tmr_last;
    logic                       tmr_done;
`ifdef SENSOR_LINK_CHKSUM_EN
    logic                       gap_to_c;
`endif

    assign in_ready = ~full;
    assign tmr_done = tmr_last | tmr_zero;

    // Every SEND state is followed by GAP or TAIL, so each one arms the timer.
    always_comb begin
        tmr_load = (state == SL_SEND0) || (state == SL_SEND1);
`ifdef SENSOR_LINK_CHKSUM_EN
        if (state == SL_SENDC) tmr_load = 1'b1;
`endif
    end

    sl_gap_timer #(.WIDTH(8)) u_gap_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (GAP_LOAD),
        .zero  (tmr_zero),
        .last  (tmr_last)
    );

    // in_ready is low while full, so capture and drain never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
            full <= 1'b0;
        end else if (in_valid && !full) begin
            hold <= {rain, soil};
            full <= 1'b1;
        end else if (state == SL_IDLE && full) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SL_IDLE;
            work       <= '0;
            data_bus   <= '0;
            ss         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef SENSOR_LINK_CHKSUM_EN
            gap_to_c   <= 1'b0;
`endif
        end else begin
            // NOTE: pulse outputs default low each cycle; only the states that strobe override them.
            ss         <= 1'b0;
            data_bus   <= '0;
            frame_done <= 1'b0;
            case (state)
                SL_IDLE: begin
                    if (full) begin
                        state    <= SL_SEND0;
                        busy     <= 1'b1;
                        ss       <= 1'b1;
                        data_bus <= hold[2*SL_BYTE_W-1 -: SL_BYTE_W];
`ifdef SENSOR_LINK_CHKSUM_EN
                        work     <= {hold[SL_BYTE_W-1:0],
                                     sl_chk(hold[2*SL_BYTE_W-1 -: SL_BYTE_W], hold[SL_BYTE_W-1:0])};
`else
                        work     <= hold[SL_BYTE_W-1:0];
`endif
                    end
                end
                SL_SEND0: begin
`ifdef SENSOR_LINK_CHKSUM_EN
                    gap_to_c <= 1'b0;
`endif
                    if (NO_GAP) begin
                        state    <= SL_SEND1;
                        ss       <= 1'b1;
                        data_bus <= work[WORK_W-1 -: SL_BYTE_W];
                    end else begin
                        state <= SL_GAP;
                    end
                end
                SL_GAP: begin
                    if (tmr_done) begin
                        ss <= 1'b1;
`ifdef SENSOR_LINK_CHKSUM_EN
                        if (gap_to_c) begin
                            state    <= SL_SENDC;
                            data_bus <= work[SL_BYTE_W-1:0];
                        end else
`endif
                        begin
                            state    <= SL_SEND1;
                            data_bus <= work[WORK_W-1 -: SL_BYTE_W];
                        end
                    end
                end
`ifdef SENSOR_LINK_CHKSUM_EN
                SL_SEND1: begin
                    gap_to_c <= 1'b1;
                    if (NO_GAP) begin
                        state    <= SL_SENDC;
                        ss       <= 1'b1;
                        data_bus <= work[SL_BYTE_W-1:0];
                    end else begin
                        state <= SL_GAP;
                    end
                end
                SL_SENDC: begin
`else
                SL_SEND1: begin
`endif
                    frame_done <= 1'b1;
                    if (NO_GAP) begin
                        state <= SL_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= SL_TAIL;
                    end
                end
                SL_TAIL: begin
                    if (tmr_done) begin
                        state <= SL_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= SL_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_link_tx.sv
// Scoreboard bench for sensor_link_tx at GAP_CYCLES = 2, 0 and 255.
// Honours SENSOR_LINK_CHKSUM_EN for the expected frame length and checksum byte.
module tb_sensor_link_tx;

`ifdef SENSOR_LINK_CHKSUM_EN
    localparam int FL = 3;
`else
    localparam int FL = 2;
`endif
    localparam int GA = 2;
    localparam int GB = 0;
    localparam int GC = 255;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rain  = 8'h00;
    logic [7:0] soil  = 8'h00;
    logic [2:0] vld   = 3'b000;
    logic [2:0] rdy;
    logic [2:0] ss;
    logic [2:0] busy;
    logic [2:0] fd;
    logic [7:0] db [3];

    always #5 clk = ~clk;

    sensor_link_tx #(.GAP_CYCLES(GA)) dut_a (
        .clk(clk), .rst_n(rst_n), .rain(rain), .soil(soil), .in_valid(vld[0]),
        .in_ready(rdy[0]), .data_bus(db[0]), .ss(ss[0]), .busy(busy[0]), .frame_done(fd[0]));
    sensor_link_tx #(.GAP_CYCLES(GB)) dut_b (
        .clk(clk), .rst_n(rst_n), .rain(rain), .soil(soil), .in_valid(vld[1]),
        .in_ready(rdy[1]), .data_bus(db[1]), .ss(ss[1]), .busy(busy[1]), .frame_done(fd[1]));
    sensor_link_tx #(.GAP_CYCLES(GC)) dut_c (
        .clk(clk), .rst_n(rst_n), .rain(rain), .soil(soil), .in_valid(vld[2]),
        .in_ready(rdy[2]), .data_bus(db[2]), .ss(ss[2]), .busy(busy[2]), .frame_done(fd[2]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, got, got, exp, exp, cyc);
        end
    endtask

    typedef struct {
        int         dut;
        logic [7:0] b;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   act = 0;
    int   ss_log [$];
    int   fd_log [$];
    int   ir_log [$];
    int   bf_log [$];
    logic prev_busy = 1'b0;

    // Monitor: every strobe pops the scoreboard; cycle logs feed the timing checks.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (ss[d]) begin
                    if (sb.size() == 0) begin
                        check($sformatf("unexpected strobe dut%0d", d), int'(db[d]), -1);
                    end else begin
                        mon_e = sb.pop_front();
                        check("strobe dut", d, mon_e.dut);
                        check("strobe byte", int'(db[d]), int'(mon_e.b));
                    end
                    if (d == act) ss_log.push_back(cyc);
                end
            end
            if (fd[act]) fd_log.push_back(cyc);
            if (!rdy[act]) ir_log.push_back(cyc);
            if (prev_busy && !busy[act]) bf_log.push_back(cyc);
            prev_busy = busy[act];
        end
    end

    function automatic int at(input int q [$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs(input int d);
        act = d;
        ss_log.delete();
        fd_log.delete();
        ir_log.delete();
        bf_log.delete();
    endtask

    // Leaves in_valid high after acceptance; the caller drops it or sends again.
    task automatic send(input int d, input logic [7:0] r, input logic [7:0] s,
                        input int nbytes, output int n);
        int budget;
        budget = 0;
        @(negedge clk);
        rain   = r;
        soil   = s;
        vld[d] = 1'b1;
        while (!rdy[d] && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 2000) check("accept timeout", int'(rdy[d]), 1);
        n = cyc;
        if (nbytes >= 1) sb.push_back('{d, r});
        if (nbytes >= 2) sb.push_back('{d, s});
`ifdef SENSOR_LINK_CHKSUM_EN
        if (nbytes >= 3) sb.push_back('{d, r ^ s});
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d);
        int k;
        k = 0;
        repeat (2) @(negedge clk);
        while ((busy[d] || !rdy[d] || sb.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check("idle timeout", int'(busy[d]), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, na, nb, nc;

        repeat (3) @(negedge clk);
        check("reset in_ready", int'(rdy[0]), 1);
        check("reset ss", int'(ss[0]), 0);
        check("reset data_bus", int'(db[0]), 0);
        check("reset busy", int'(busy[0]), 0);
        check("reset frame_done", int'(fd[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame, GAP_CYCLES = 2
        clear_logs(0);
        send(0, 8'h3C, 8'hA1, FL, n);
        vld[0] = 1'b0;
        wait_idle(0);
        check("single strobe count", ss_log.size(), FL);
        check("single rain cycle", at(ss_log, 0), n + 2);
        check("single soil cycle", at(ss_log, 1), n + 3 + GA);
        check("single frame_done cycle", at(fd_log, 0), n + 2 + (FL - 1) * (GA + 1) + 1);
        check("single busy drop cycle", at(bf_log, 0), n + 2 + (FL - 1) * (GA + 1) + 1 + GA);
        check("single in_ready low count", ir_log.size(), 1);
        check("single in_ready low cycle", at(ir_log, 0), n + 1);

        // Back-to-back frames, GAP_CYCLES = 0
        clear_logs(1);
        send(1, 8'h01, 8'h02, FL, na);
        send(1, 8'h03, 8'h04, FL, nb);
        vld[1] = 1'b0;
        wait_idle(1);
        check("b2b second accept", nb, na + 2);
        check("b2b strobe count", ss_log.size(), 2 * FL);
        for (int i = 0; i < FL; i++) begin
            check("b2b frame1 strobe cycle", at(ss_log, i), na + 2 + i);
            check("b2b frame2 strobe cycle", at(ss_log, FL + i), na + 3 + FL + i);
        end
        check("b2b in_ready low count", ir_log.size(), 1 + FL);
        check("b2b in_ready low first", at(ir_log, 0), na + 1);
        for (int i = 0; i < FL; i++) begin
            check("b2b in_ready low buffered", at(ir_log, 1 + i), na + 3 + i);
        end
        check("b2b frame_done first", at(fd_log, 0), na + 2 + FL);

        // Backpressure: third pair waits while the buffer holds the second
        clear_logs(0);
        send(0, 8'h11, 8'h22, FL, na);
        send(0, 8'h33, 8'h44, FL, nb);
        send(0, 8'hFF, 8'hEE, FL, nc);
        vld[0] = 1'b0;
        wait_idle(0);
        check("bp second accept", nb, na + 2);
        check("bp third accept", nc, na + 2 + FL * (GA + 1) + 1);
        check("bp strobe count", ss_log.size(), 3 * FL);

        // Reset one cycle after the rain strobe, with a second pair buffered
        clear_logs(0);
        send(0, 8'h77, 8'h88, 1, n);
        send(0, 8'h99, 8'hAA, 0, n2);
        vld[0] = 1'b0;
        @(negedge clk);
        check("pre-reset busy", int'(busy[0]), 1);
        check("pre-reset in_ready", int'(rdy[0]), 0);
        rst_n = 1'b0;
        #1;
        check("mid reset ss", int'(ss[0]), 0);
        check("mid reset data_bus", int'(db[0]), 0);
        check("mid reset busy", int'(busy[0]), 0);
        check("mid reset in_ready", int'(rdy[0]), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mid reset strobe count", ss_log.size(), 1);
        check("mid reset rain cycle", at(ss_log, 0), n + 2);
        check("mid reset idle busy", int'(busy[0]), 0);

        // Checksum pair; frame_done follows the final strobe
        clear_logs(0);
        send(0, 8'h5A, 8'h0F, FL, n);
        vld[0] = 1'b0;
        wait_idle(0);
        check("chk strobe count", ss_log.size(), FL);
        check("chk frame_done after last strobe", at(fd_log, 0), at(ss_log, FL - 1) + 1);

        // Boundary: GAP_CYCLES = 255
        clear_logs(2);
        send(2, 8'h00, 8'hFF, FL, n);
        vld[2] = 1'b0;
        wait_idle(2);
        check("gap255 strobe count", ss_log.size(), FL);
        check("gap255 rain cycle", at(ss_log, 0), n + 2);
        check("gap255 idle between strobes", at(ss_log, 1) - at(ss_log, 0) - 1, GC);
        check("gap255 frame_done", at(fd_log, 0), n + 2 + (FL - 1) * (GC + 1) + 1);
        check("gap255 busy drop", at(bf_log, 0), n + 2 + (FL - 1) * (GC + 1) + 1 + GC);

        check("scoreboard drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sensor_link_tx.md
# sensor_link_tx

Host-side transmitter for the fuzzy risk estimator's byte-strobe sensor link. It accepts (rainfall, soil-moisture) sample pairs over a valid/ready handshake. Each pair is serialized as a frame of strobed bytes on `data_bus`/`ss`, which the estimator's input controller consumes. A one-frame holding buffer lets the next sample pair be accepted while the current frame is still on the wire.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: idle cycles (`ss` low) inserted after every strobe. Legal range 0..255.

Ports:
- `clk` input, 1 bit: single clock; all state is updated on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `rain` input, 8 bits: rainfall sample, unsigned.
- `soil` input, 8 bits: soil-moisture sample, unsigned.
- `in_valid` input, 1 bit: the sample pair on `rain`/`soil` is valid.
- `in_ready` output, 1 bit: the holding buffer is empty; the pair is accepted when `in_valid & in_ready`.
- `data_bus` output, 8 bits: link byte; valid only while `ss` is 1, and driven to 0x00 otherwise.
- `ss` output, 1 bit: byte strobe; high for exactly one cycle per byte.
- `busy` output, 1 bit: a frame is in flight, i.e. the FSM is not in IDLE.
- `frame_done` output, 1 bit: one-cycle pulse in the cycle after the final strobe of a frame.

## Operation
- **Frame format:** byte 0 = `rain`, byte 1 = `soil`, optionally followed by a checksum byte (see Configuration). Bytes are sent in that order with no header.
- **Holding buffer:**
  - One 16-bit register plus a `full` flag; `in_ready = ~full`.
  - On acceptance the register captures `{rain, soil}` and `full` is set.
  - When the FSM leaves IDLE it moves the buffer into a shift/working register and clears `full` in the same cycle.
  - Acceptance and drain in the same cycle are impossible, because `in_ready` is 0 while full.
- **FSM states and transitions:**
  - IDLE → SEND0 when `full`.
  - SEND0 → GAP.
  - GAP → SEND1 after `GAP_CYCLES` cycles.
  - SEND1 → (GAP → SENDC when checksum is enabled) → TAIL.
  - TAIL waits `GAP_CYCLES` cycles, then → IDLE.
  - With `GAP_CYCLES = 0`, GAP and TAIL last zero cycles and strobes are back-to-back.
- `ss = 1` and `data_bus = working byte` only in SEND states.
- A single gap counter of 8 bits loads `GAP_CYCLES` on entry to GAP or TAIL and counts down to 0.
- `frame_done` is registered and asserted in the cycle after the last SEND state.
- A pair accepted mid-frame waits in the buffer and starts the next frame directly from TAIL's exit. The FSM passes through IDLE for one cycle, so consecutive frames are separated by `GAP_CYCLES + 1` idle cycles.
- **Reset mid-frame:** takes effect asynchronously. The frame in progress is abandoned and the buffer is emptied; a partial frame is never resumed.

## Timing
- **Reset values:** `in_ready` = 1, `data_bus` = 0x00, `ss` = 0, `busy` = 0, `frame_done` = 0, FSM = IDLE, `full` = 0.
- **Latency:** with the FSM idle, a handshake in cycle N gives `full` in N+1 and the first strobe (`rain`) in N+2. The `soil` strobe follows in N+3+`GAP_CYCLES`.
- Every output is registered; there is no combinational path from input to output except `in_ready`, which is derived from a register only.
- **Throughput:** one frame per (2 or 3 strobes) + (2 or 3)×`GAP_CYCLES` + 1 cycles.

## Configuration
- `SENSOR_LINK_CHKSUM_EN` defined:
  - A third byte, `rain ^ soil`, is strobed after `soil` following a GAP.
  - `frame_done` follows the checksum strobe.
  - The receiving controller must be built with the same macro.
- Undefined: frames are exactly two bytes, and the SENDC state and XOR logic are absent.

## Structure
- Shared package `sensor_link_pkg`:
  - FSM state enum.
  - `SL_FRAME_LEN` constant (2 or 3, selected by the macro).
  - `SL_BYTE_W` = 8.
  - Checksum function `sl_chk(a, b)`, shared with the receiver.
- One natural sub-module: `sl_gap_timer`, a load/count-down/zero-flag counter reused by the receiver's timeout logic.

## Test plan
- **Single frame** (`GAP_CYCLES` = 2, reset released, idle): send `rain` = 0x3C, `soil` = 0xA1.
  - Required: `ss` pulses at N+2 with 0x3C and at N+5 with 0xA1.
  - Required: `frame_done` at N+6, then `busy` drops after the 2-cycle TAIL.
- **Back-to-back frames** (`GAP_CYCLES` = 0): hold `in_valid` high for pairs (0x01, 0x02) and (0x03, 0x04).
  - Required: strobes 0x01, 0x02, one idle cycle, then 0x03, 0x04.
  - Required: `in_ready` is 0 for exactly the cycles the buffer is full.
- **Backpressure:** with a frame in flight and the buffer full, assert `in_valid` with (0xFF, 0xEE) → the pair is not accepted and not lost; it is sent after the current frame.
- **Mid-frame reset:** assert `rst_n` = 0 one cycle after the `rain` strobe.
  - Required immediately: `ss` = 0, `data_bus` = 0x00, `busy` = 0, `in_ready` = 1.
  - Required after release: no `soil` strobe ever appears.
- **Checksum** (with `SENSOR_LINK_CHKSUM_EN`): send (0x5A, 0x0F) → strobes 0x5A, 0x0F, 0x55 → `frame_done` after the 0x55 strobe.
- **Boundary:** `GAP_CYCLES` = 255 with the pair (0x00, 0xFF) → exactly 255 idle cycles between strobes, and the counter does not wrap.
